// File: rtl/elastic_pipe_pkg.sv
// Shared defaults and helpers for the elastic delay pipeline.
package elastic_pipe_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 4;

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One pipeline slot: a valid flag plus a WIDTH-bit data register.
// Ports:
//   clk, rst          clock, async active-high reset
//   en                slot advances this cycle (takes upstream contents)
//   flush             synchronous clear of the valid flag
//   up_valid/up_data  contents offered by the previous slot (or the input)
//   valid/data        registered slot contents
module elastic_pipe_stage
  import elastic_pipe_pkg::*;
#(
  parameter int unsigned          WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Valid flag: flush wins over advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= up_valid;
    end
  end

  // Data only loads real words, so bubbles never toggle the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= RESET_VAL;
    end else if (en && up_valid) begin
      data <= up_data;
    end
  end

endmodule

// File: rtl/elastic_pipe_delay.sv
// Elastic delay pipeline: DEPTH register slots with valid/ready backpressure,
// bubble compression, synchronous flush and an occupancy count.
// Ports:
//   clk, rst                       clock, async active-high reset
//   flush                          clear all slot valids at the next edge
//   in_valid/in_ready/in_data      upstream handshake
//   out_valid/out_ready/out_data   downstream handshake (last slot)
//   count                          number of valid slots, 0..DEPTH
//   idle                           count == 0
module elastic_pipe_delay
  import elastic_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = WIDTH_DEF,
  parameter int unsigned      DEPTH     = DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          idle
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] en;
  logic             accept;
  logic             emit;
  logic [CW-1:0]    cnt_nxt;

  // Ready chain from the output end back: a slot may advance if it is
  // empty or the slot ahead of it is advancing.
  always_comb begin
    en            = '0;
    en[DEPTH-1]   = ~valid_q[DEPTH-1] | out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      en[i] = ~valid_q[i] | en[i+1];
    end
  end

  assign in_ready  = en[0] & ~flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // Slot chain; slot 0 takes the input, flush masks the input valid.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (i == 0) begin : g_head
      assign up_v = in_valid & ~flush;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = valid_q[i-1];
      assign up_d = data_q[i-1];
    end

    elastic_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .flush    (flush),
      .up_valid (up_v),
      .up_data  (up_d),
      .valid    (valid_q[i]),
      .data     (data_q[i])
    );
  end

  // Occupancy bookkeeping; a word leaving during flush is not a transfer.
  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready & ~flush;

  always_comb begin
    cnt_nxt = count;
    if (flush) begin
      cnt_nxt = '0;
    end else if (accept && !emit) begin
      cnt_nxt = count + CW'(1);
    end else if (!accept && emit) begin
      cnt_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= cnt_nxt;
    end
  end

  assign idle = (count == '0);

endmodule

// File: tb/tb_elastic_pipe_delay.sv
// Self-checking bench: two pipe instances (8-bit x 4 slots, 32-bit x 1 slot)
// compared every cycle against a slot-occupancy reference model.
module tb_elastic_pipe_delay;

  localparam int unsigned WA = 8;
  localparam int unsigned DA = 4;
  localparam int unsigned WB = 32;
  localparam int unsigned DB = 1;
  localparam logic [WA-1:0] RST_A = 8'h5A;
  localparam logic [WB-1:0] RST_B = 32'hFFFF_0000;

  logic          clk;
  logic          rst;

  logic          flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, idle_a;
  logic [WA-1:0] in_data_a, out_data_a;
  logic [2:0]    count_a;

  logic          flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, idle_b;
  logic [WB-1:0] in_data_b, out_data_b;
  logic [0:0]    count_b;

  elastic_pipe_delay #(.WIDTH(WA), .DEPTH(DA), .RESET_VAL(RST_A)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .count(count_a), .idle(idle_a)
  );

  elastic_pipe_delay #(.WIDTH(WB), .DEPTH(DB), .RESET_VAL(RST_B)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .count(count_b), .idle(idle_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: per instance, an array of slots each holding a word or nothing.
  bit          m_v [2][4];
  logic [31:0] m_d [2][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int m_count(input int k, input int d);
    int c = 0;
    for (int i = 0; i < d; i++) c += int'(m_v[k][i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_v[0][i] = 1'b0;
      m_v[1][i] = 1'b0;
      m_d[0][i] = 32'(RST_A);
      m_d[1][i] = RST_B;
    end
  endtask

  // One clock of the model: the head word leaves if taken, every word then
  // slides forward into a free slot (one step per cycle), then the input
  // enters slot 0 if free. Flush empties every slot afterwards.
  task automatic model_step(input int k, input int d, input bit iv, input logic [31:0] id,
                            input bit ordy, input bit fl, output bit rdy);
    if (m_v[k][d-1] && ordy) m_v[k][d-1] = 1'b0;
    for (int i = d - 1; i >= 1; i--) begin
      if (!m_v[k][i] && m_v[k][i-1]) begin
        m_v[k][i]   = 1'b1;
        m_d[k][i]   = m_d[k][i-1];
        m_v[k][i-1] = 1'b0;
      end
    end
    rdy = !m_v[k][0] && !fl;
    if (iv && rdy) begin
      m_v[k][0] = 1'b1;
      m_d[k][0] = id;
    end
    if (fl) for (int i = 0; i < d; i++) m_v[k][i] = 1'b0;
  endtask

  task automatic check_outputs();
    check("a_out_valid", 32'(out_valid_a), 32'(m_v[0][DA-1]));
    if (m_v[0][DA-1]) check("a_out_data", 32'(out_data_a), m_d[0][DA-1]);
    check("a_count", 32'(count_a), 32'(m_count(0, DA)));
    check("a_idle", 32'(idle_a), 32'(m_count(0, DA) == 0));
    check("b_out_valid", 32'(out_valid_b), 32'(m_v[1][DB-1]));
    if (m_v[1][DB-1]) check("b_out_data", out_data_b, m_d[1][DB-1]);
    check("b_count", 32'(count_b), 32'(m_count(1, DB)));
    check("b_idle", 32'(idle_b), 32'(m_count(1, DB) == 0));
  endtask

  // Check registered state, drive this cycle's inputs, check in_ready, advance model.
  task automatic cycle(input bit va, input logic [31:0] da, input bit ra, input bit fa,
                       input bit vb, input logic [31:0] db, input bit rb, input bit fb);
    bit rdy_a, rdy_b;
    @(negedge clk);
    check_outputs();
    in_valid_a = va; in_data_a = da[WA-1:0]; out_ready_a = ra; flush_a = fa;
    in_valid_b = vb; in_data_b = db;         out_ready_b = rb; flush_b = fb;
    #1;
    model_step(0, DA, va, 32'(da[WA-1:0]), ra, fa, rdy_a);
    check("a_in_ready", 32'(in_ready_a), 32'(rdy_a));
    model_step(1, DB, vb, db, rb, fb, rdy_b);
    check("b_in_ready", 32'(in_ready_b), 32'(rdy_b));
  endtask

  task automatic cyc_a(input bit v, input logic [31:0] d, input bit r, input bit f);
    cycle(v, d, r, f, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic cyc_b(input bit v, input logic [31:0] d, input bit r, input bit f);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, v, d, r, f);
  endtask

  initial begin
    rst = 1'b1;
    flush_a = 0; in_valid_a = 0; in_data_a = '0; out_ready_a = 0;
    flush_b = 0; in_valid_b = 0; in_data_b = '0; out_ready_b = 0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("a_rst_data", 32'(out_data_a), 32'(RST_A));
    check("b_rst_data", out_data_b, RST_B);
    check_outputs();
    rst = 1'b0;

    // Three words back-to-back, downstream always ready
    cyc_a(1, 32'hA1, 1, 0);
    cyc_a(1, 32'hA2, 1, 0);
    cyc_a(1, 32'hA3, 1, 0);
    repeat (7) cyc_a(0, 32'h0, 1, 0);

    // Stalled output fills the pipe, then full-rate streaming
    for (int i = 0; i < 6; i++) cyc_a(1, 32'hA1 + 32'(i), 0, 0);
    for (int i = 0; i < 6; i++) cyc_a(1, 32'hB0 + 32'(i), 1, 0);
    repeat (6) cyc_a(0, 32'h0, 1, 0);

    // Bubble compression under stall
    cyc_a(1, 32'hC1, 0, 0);
    repeat (2) cyc_a(0, 32'h0, 0, 0);
    cyc_a(1, 32'hC2, 0, 0);
    repeat (4) cyc_a(0, 32'h0, 0, 0);
    repeat (4) cyc_a(0, 32'h0, 1, 0);

    // Flush with words in flight, input and output both offered
    cyc_a(1, 32'hD1, 1, 0);
    cyc_a(1, 32'hD2, 1, 0);
    cyc_a(1, 32'hD3, 1, 0);
    cyc_a(0, 32'h0, 0, 0);
    cyc_a(0, 32'h0, 0, 0);
    cyc_a(1, 32'hD4, 1, 1);
    repeat (5) cyc_a(0, 32'h0, 1, 0);

    // Asynchronous reset mid-stream
    cyc_a(1, 32'hE1, 1, 0);
    cyc_a(1, 32'hE2, 1, 0);
    cyc_a(1, 32'hE3, 1, 0);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    in_valid_a = 1'b0;
    #1;
    check("a_midrst_valid", 32'(out_valid_a), 32'h0);
    check("a_midrst_data", 32'(out_data_a), 32'(RST_A));
    check("a_midrst_count", 32'(count_a), 32'h0);
    check("a_midrst_idle", 32'(idle_a), 32'h1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) cyc_a(0, 32'h0, 1, 0);

    // Single-slot wide instance: alternating downstream ready
    for (int i = 0; i < 10; i++)
      cyc_b(1, (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678, bit'(i % 2 == 0), 0);
    repeat (3) cyc_b(0, 32'h0, 1, 0);

    // Random traffic on both instances
    for (int n = 0; n < 2000; n++)
      cycle(bit'($urandom_range(0, 3) != 0), $urandom, bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 31) == 0),
            bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 31) == 0));

    @(negedge clk);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
